reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port successor to the CPU register file. It has NUM_READ combinational read ports and NUM_WRITE synchronous write ports, with optional write-to-read bypass and an optional hardwired zero register. A per-register busy scoreboard lets the issue stage stall on pending writebacks. It sits between decode/issue (reads, claims) and writeback (writes).

Parameters:
WORD_SIZE, 32, data width in bits
REG_INDEX, 5, register address width
REG_FILE_SIZE, 32, number of registers; must equal 2**REG_INDEX
NUM_READ, 3, number of read ports (1..4)
NUM_WRITE, 2, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  input  1  clock; all state updates on the rising edge
reset_enable  input  1  synchronous active-high reset
get_num  input  NUM_READ*REG_INDEX  read addresses; port k occupies bits [k*REG_INDEX +: REG_INDEX]
out  output  NUM_READ*WORD_SIZE  read data; port k occupies bits [k*WORD_SIZE +: WORD_SIZE]
out_busy  output  NUM_READ  busy bit of the register addressed by port k
set_enable  input  NUM_WRITE  write enable per write port
set_num  input  NUM_WRITE*REG_INDEX  write addresses
set_val  input  NUM_WRITE*WORD_SIZE  write data
claim_enable  input  1  mark register claim_num busy (instruction issued)
claim_num  input  REG_INDEX  register to claim

Behaviour:
- Reset: when reset_enable=1 at a rising edge, every register becomes 0 and every busy bit becomes 0. Reset has priority over same-cycle writes and claims. After reset, all out = 0 and all out_busy = 0.
- Read: combinational, zero latency. out[k] = register[get_num[k]], unless bypass or the zero register applies.
- Write: on a rising edge, for each port w with set_enable[w]=1, register[set_num[w]] <= set_val[w]. The result is visible on out the next cycle.
- Write collision: if two enabled write ports target the same address, the higher port index wins.
- Bypass (BYPASS=1): if get_num[k] matches set_num[w] of any enabled write port, out[k] = set_val of the highest matching port in the same cycle.
- Bypass (BYPASS=0): out shows the old value until the edge.
- Zero register (ZERO_REG=1):
  - writes to address 0 are dropped;
  - reads of address 0 return 0, including when bypass would apply;
  - claims of address 0 are ignored.
- Scoreboard:
  - busy[r] is set at the edge when claim_enable=1 and claim_num=r;
  - busy[r] is cleared at the edge when any enabled write port targets r.
- Simultaneous claim and write to the same r: busy stays 1 (a new producer has claimed r). The write data is still stored.
- out_busy[k] = busy[get_num[k]], taken from the registered state, with no bypass.
  - When a write clearing busy is in flight and BYPASS=1: out_busy is still 1 that cycle, but out carries the forwarded value. The issue stage must treat busy&&!forward as a stall; a forward indicator is not exported.
- Claiming an already-busy register keeps it busy, with no error.
- Reset asserted mid-operation discards all pending state on that edge. Inputs in the reset cycle are ignored.
- No combinational path from set_* to out when BYPASS=0.
- Elaboration must fail (generate-time $error or equivalent) if REG_FILE_SIZE != 2**REG_INDEX.

Test Plan:
- Reset, then read regs 1,2,3 on ports 0..2 -> all out=0, out_busy=000. Write reg5=0xDEADBEEF on port 0, read reg5 next cycle -> 0xDEADBEEF.
- BYPASS=1: write reg7=0x12 and read reg7 in the same cycle -> out=0x12 that cycle. Rebuild with BYPASS=0 -> old value 0 that cycle, 0x12 the next.
- Collision: port0 writes reg4=0xAA and port1 writes reg4=0xBB in one cycle -> reg4 reads 0xBB. Bypass read of reg4 that cycle -> 0xBB.
- Zero register: write reg0=0xFFFF and claim reg0 -> reg0 reads 0, out_busy=0. Rebuild with ZERO_REG=0 -> reads 0xFFFF.
- Scoreboard:
  - claim reg9 -> out_busy for reg9 =1 next cycle;
  - write reg9=0x5 -> busy 0 the following cycle;
  - claim and write reg9 in the same cycle -> busy remains 1, value 0x5 stored.
- Reset mid-operation: with reg3=0x77 and busy[3]=1, assert reset_enable together with a write reg3=0x99 -> next cycle reg3=0, busy[3]=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass, optional zero
// register and a per-register busy scoreboard for issue-stage stalls.
module reg_file_mp #(
    parameter int WORD_SIZE     = 32,
    parameter int REG_INDEX     = 5,
    parameter int REG_FILE_SIZE = 32,
    parameter int NUM_READ      = 3,
    parameter int NUM_WRITE     = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input  logic                           clk,
    input  logic                           reset_enable,
    input  logic [NUM_READ*REG_INDEX-1:0]  get_num,
    output logic [NUM_READ*WORD_SIZE-1:0]  out,
    output logic [NUM_READ-1:0]            out_busy,
    input  logic [NUM_WRITE-1:0]           set_enable,
    input  logic [NUM_WRITE*REG_INDEX-1:0] set_num,
    input  logic [NUM_WRITE*WORD_SIZE-1:0] set_val,
    input  logic                           claim_enable,
    input  logic [REG_INDEX-1:0]           claim_num
);

    localparam bit ZR = (ZERO_REG != 0);
    localparam bit BP = (BYPASS != 0);

    if (REG_FILE_SIZE != 2**REG_INDEX) begin : g_bad_size
        $error("reg_file_mp: REG_FILE_SIZE must equal 2**REG_INDEX");
    end
    if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_rd
        $error("reg_file_mp: NUM_READ must be 1..4");
    end
    if (NUM_WRITE < 1 || NUM_WRITE > 2) begin : g_bad_wr
        $error("reg_file_mp: NUM_WRITE must be 1..2");
    end

    logic [WORD_SIZE-1:0]     regs_q [REG_FILE_SIZE];
    logic [WORD_SIZE-1:0]     regs_d [REG_FILE_SIZE];
    logic [REG_FILE_SIZE-1:0] busy_q;
    logic [REG_FILE_SIZE-1:0] busy_d;

    logic [REG_INDEX-1:0] rd_addr [NUM_READ];
    logic [WORD_SIZE-1:0] rd_data [NUM_READ];
    logic [REG_INDEX-1:0] wr_addr [NUM_WRITE];
    logic [WORD_SIZE-1:0] wr_data [NUM_WRITE];
    logic [NUM_WRITE-1:0] wr_en;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        assign rd_addr[k] = get_num[k*REG_INDEX +: REG_INDEX];
        assign out[k*WORD_SIZE +: WORD_SIZE] = rd_data[k];
        assign out_busy[k] = busy_q[rd_addr[k]];
    end

    // Writes to the zero register are filtered once here for both state and bypass.
    for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
        assign wr_addr[w] = set_num[w*REG_INDEX +: REG_INDEX];
        assign wr_data[w] = set_val[w*WORD_SIZE +: WORD_SIZE];
        assign wr_en[w]   = set_enable[w] && !(ZR && wr_addr[w] == '0);
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        // Ascending order lets the higher port win a collision.
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (wr_en[w]) begin
                regs_d[wr_addr[w]] = wr_data[w];
                busy_d[wr_addr[w]] = 1'b0;
            end
        end
        // A claim after the write keeps a freshly re-issued register busy.
        if (claim_enable && !(ZR && claim_num == '0)) begin
            busy_d[claim_num] = 1'b1;
        end
        if (reset_enable) begin
            for (int r = 0; r < REG_FILE_SIZE; r++) begin
                regs_d[r] = '0;
            end
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            rd_data[k] = regs_q[rd_addr[k]];
            if (BP) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (wr_en[w] && wr_addr[w] == rd_addr[k]) begin
                        rd_data[k] = wr_data[w];
                    end
                end
            end
            if (ZR && rd_addr[k] == '0) begin
                rd_data[k] = '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default build (inst 0) and a
// BYPASS=0 / ZERO_REG=0 build (inst 1) driven with the same vectors.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset_enable;
    logic [14:0] get_num;
    logic [95:0] out_a, out_b;
    logic [2:0]  busy_a, busy_b;
    logic [1:0]  set_enable;
    logic [9:0]  set_num;
    logic [63:0] set_val;
    logic        claim_enable;
    logic [4:0]  claim_num;

    always #5 clk = ~clk;

    reg_file_mp dut_a (
        .clk(clk), .reset_enable(reset_enable), .get_num(get_num),
        .out(out_a), .out_busy(busy_a), .set_enable(set_enable),
        .set_num(set_num), .set_val(set_val),
        .claim_enable(claim_enable), .claim_num(claim_num)
    );

    reg_file_mp #(.ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset_enable(reset_enable), .get_num(get_num),
        .out(out_b), .out_busy(busy_b), .set_enable(set_enable),
        .set_num(set_num), .set_val(set_val),
        .claim_enable(claim_enable), .claim_num(claim_num)
    );

    typedef struct {
        int          inst;
        int          port;
        bit          chk_d;
        logic [31:0] d;
        logic        b;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Monitor: outputs are combinational, so compare at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] gd;
            logic        gb;
            e = sb.pop_front();
            gd = (e.inst == 0) ? out_a[e.port*32 +: 32] : out_b[e.port*32 +: 32];
            gb = (e.inst == 0) ? busy_a[e.port] : busy_b[e.port];
            if (e.chk_d) begin
                total++;
                if (gd !== e.d) begin
                    bad++;
                    $display("FAIL %s inst%0d port%0d data: got %h want %h",
                             e.name, e.inst, e.port, gd, e.d);
                end
            end
            total++;
            if (gb !== e.b) begin
                bad++;
                $display("FAIL %s inst%0d port%0d busy: got %b want %b",
                         e.name, e.inst, e.port, gb, e.b);
            end
        end
    end

    task automatic idle();
        reset_enable = 1'b0;
        get_num      = '0;
        set_enable   = '0;
        set_num      = '0;
        set_val      = '0;
        claim_enable = 1'b0;
        claim_num    = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        get_num[k*5 +: 5] = a;
    endtask

    task automatic wr(input int w, input logic [4:0] a, input logic [31:0] v);
        set_enable[w]      = 1'b1;
        set_num[w*5 +: 5]  = a;
        set_val[w*32 +: 32] = v;
    endtask

    task automatic claim(input logic [4:0] a);
        claim_enable = 1'b1;
        claim_num    = a;
    endtask

    task automatic expect_rd(input int inst, input int k, input bit cd,
                             input logic [31:0] d, input logic b,
                             input string name);
        exp_t e;
        e.inst = inst; e.port = k; e.chk_d = cd;
        e.d = d; e.b = b; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        idle();
        #1;
        reset_enable = 1'b1;

        next();
        rd(0, 5'd1); rd(1, 5'd2); rd(2, 5'd3);
        wr(0, 5'd5, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                expect_rd(i, k, 1, 32'h0, 1'b0, "reset");

        next();
        rd(0, 5'd5);
        expect_rd(0, 0, 1, 32'hDEADBEEF, 1'b0, "wr_rd");
        expect_rd(1, 0, 1, 32'hDEADBEEF, 1'b0, "wr_rd");

        next();
        wr(0, 5'd7, 32'h12); rd(0, 5'd7);
        expect_rd(0, 0, 1, 32'h12, 1'b0, "bypass");
        expect_rd(1, 0, 1, 32'h0, 1'b0, "no_bypass");

        next();
        rd(0, 5'd7);
        expect_rd(0, 0, 1, 32'h12, 1'b0, "after_bypass");
        expect_rd(1, 0, 1, 32'h12, 1'b0, "after_bypass");

        next();
        wr(0, 5'd4, 32'hAA); wr(1, 5'd4, 32'hBB); rd(0, 5'd4);
        expect_rd(0, 0, 1, 32'hBB, 1'b0, "coll_bypass");
        expect_rd(1, 0, 1, 32'h0, 1'b0, "coll_nobyp");

        next();
        rd(0, 5'd4);
        expect_rd(0, 0, 1, 32'hBB, 1'b0, "collision");
        expect_rd(1, 0, 1, 32'hBB, 1'b0, "collision");

        next();
        wr(0, 5'd0, 32'hFFFF); claim(5'd0); rd(0, 5'd0);
        expect_rd(0, 0, 1, 32'h0, 1'b0, "zero_byp");
        expect_rd(1, 0, 1, 32'h0, 1'b0, "zero_byp");

        next();
        rd(0, 5'd0);
        expect_rd(0, 0, 1, 32'h0, 1'b0, "zero_reg");
        expect_rd(1, 0, 1, 32'hFFFF, 1'b1, "no_zero_reg");

        next();
        claim(5'd9); rd(1, 5'd9);
        expect_rd(0, 1, 1, 32'h0, 1'b0, "claim_cyc");
        expect_rd(1, 1, 1, 32'h0, 1'b0, "claim_cyc");

        next();
        wr(1, 5'd9, 32'h5); rd(1, 5'd9);
        expect_rd(0, 1, 1, 32'h5, 1'b1, "busy_fwd");
        expect_rd(1, 1, 1, 32'h0, 1'b1, "busy_nofwd");

        next();
        wr(0, 5'd9, 32'h5); claim(5'd9); rd(1, 5'd9);
        expect_rd(0, 1, 1, 32'h5, 1'b0, "busy_clr");
        expect_rd(1, 1, 1, 32'h5, 1'b0, "busy_clr");

        next();
        rd(1, 5'd9);
        expect_rd(0, 1, 1, 32'h5, 1'b1, "claim_wr");
        expect_rd(1, 1, 1, 32'h5, 1'b1, "claim_wr");

        next();
        wr(0, 5'd3, 32'h77); claim(5'd3); rd(2, 5'd3);
        expect_rd(0, 2, 1, 32'h77, 1'b0, "pre_rst");
        expect_rd(1, 2, 1, 32'h0, 1'b0, "pre_rst");

        next();
        reset_enable = 1'b1;
        wr(0, 5'd3, 32'h99); rd(2, 5'd3);
        expect_rd(0, 2, 0, 32'h0, 1'b1, "rst_cyc");
        expect_rd(1, 2, 1, 32'h77, 1'b1, "rst_cyc");

        next();
        rd(0, 5'd5); rd(1, 5'd9); rd(2, 5'd3);
        for (int i = 0; i < 2; i++) begin
            expect_rd(i, 0, 1, 32'h0, 1'b0, "mid_rst5");
            expect_rd(i, 1, 1, 32'h0, 1'b0, "mid_rst9");
            expect_rd(i, 2, 1, 32'h0, 1'b0, "mid_rst3");
        end

        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
